// File: rtl/memory_loader_if.sv
// memory_loader_if: serial byte-stream handshake and memory write port of the loader.
// The loader connects through the slave modport; whoever feeds the stream
// (receiver, testbench) uses the master modport.
interface memory_loader_if #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDRESS = 5
);
    logic                  i_start;
    logic [7:0]            i_rx_data;
    logic                  i_rx_valid;
    logic                  o_rx_ready;
    logic [NB_DATA-1:0]    o_w_data;
    logic [NB_ADDRESS-1:0] o_w_addr;
    logic                  o_w_en;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_rx_ready, o_w_data, o_w_addr, o_w_en, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_rx_ready, o_w_data, o_w_addr, o_w_en, o_busy, o_done, o_err
    );
endinterface

// File: rtl/memory_loader.sv
// memory_loader: fills the instruction/data memory from a framed byte stream.
// Frame = one length byte L, then L little-endian words of NB_DATA/8 bytes each.
// Words are written to consecutive addresses starting at 0 through a registered
// write port. A length above N_ADDRESS aborts the load with o_err.
module memory_loader #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDRESS = 5,
    parameter int N_ADDRESS  = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    memory_loader_if.slave  bus
);
    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam int NB_WCNT  = NB_ADDRESS + 1;
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
    localparam logic [8:0]         MAX_LEN   = 9'(N_ADDRESS);

    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;

    state_t                state;
    state_t                state_next;
    logic [NB_WCNT-1:0]    word_cnt;
    logic [NB_WCNT-1:0]    len;
    logic [NB_BCNT-1:0]    byte_cnt;
    logic [NB_DATA-1:0]    word_buf;
    logic [NB_DATA-1:0]    word_next;
    logic [NB_DATA-1:0]    w_data;
    logic [NB_ADDRESS-1:0] w_addr;
    logic                  w_en;
    logic                  rx_ready;
    logic                  accept;
    logic                  can_start;
    logic                  len_zero;
    logic                  len_over;
    logic                  last_byte;
    logic                  last_word;

    assign rx_ready  = (state == LEN) || (state == DATA);
    assign accept    = bus.i_rx_valid && rx_ready;
    assign can_start = bus.i_start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign len_zero  = (bus.i_rx_data == 8'd0);
    assign len_over  = ({1'b0, bus.i_rx_data} > MAX_LEN);
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign last_word = ((word_cnt + NB_WCNT'(1)) == len);

    // Merge the incoming byte into its lane so the full word is available on the last accept
    always_comb begin
        word_next = word_buf;
        word_next[8*byte_cnt +: 8] = bus.i_rx_data;
    end

    // Next-state logic: frame parsing and word/write sequencing
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (can_start) state_next = LEN;
            end
            LEN: begin
                if (accept) begin
                    if (len_zero)      state_next = DONE;
                    else if (len_over) state_next = ERR;
                    else               state_next = DATA;
                end
            end
            DATA: begin
                if (accept && last_byte) state_next = WRITE;
            end
            WRITE: begin
                state_next = last_word ? DONE : DATA;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // Counters, word assembly and the registered write port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_cnt <= '0;
            len      <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            w_data   <= '0;
            w_addr   <= '0;
            w_en     <= 1'b0;
        end else begin
            w_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (can_start) begin
                        word_cnt <= '0;
                        len      <= '0;
                        byte_cnt <= '0;
                        w_addr   <= '0;
                    end
                end
                LEN: begin
                    if (accept && !len_zero && !len_over) len <= NB_WCNT'(bus.i_rx_data);
                end
                DATA: begin
                    if (accept) begin
                        word_buf <= word_next;
                        if (last_byte) begin
                            byte_cnt <= '0;
                            w_en     <= 1'b1;
                            w_data   <= word_next;
                            w_addr   <= word_cnt[NB_ADDRESS-1:0];
                        end else begin
                            byte_cnt <= byte_cnt + NB_BCNT'(1);
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + NB_WCNT'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_rx_ready = rx_ready;
    assign bus.o_w_data   = w_data;
    assign bus.o_w_addr   = w_addr;
    assign bus.o_w_en     = w_en;
    assign bus.o_busy     = (state == LEN) || (state == DATA) || (state == WRITE);
    assign bus.o_done     = (state == DONE);
    assign bus.o_err      = (state == ERR);
endmodule

// File: tb/tb_memory_loader.sv
// tb_memory_loader: directed and randomized frames against a frame-level model.
// The model derives the expected writes straight from the frame bytes
// (length byte, then little-endian words) and the done/err outcome from L.
module tb_memory_loader;
    localparam int NB_DATA    = 32;
    localparam int NB_ADDRESS = 5;
    localparam int N_ADDRESS  = 32;
    localparam int NB_BYTES   = NB_DATA / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0]            frameBytes[$];
    logic [NB_ADDRESS-1:0] capAddr[$];
    logic [NB_DATA-1:0]    capData[$];

    memory_loader_if #(.NB_DATA(NB_DATA), .NB_ADDRESS(NB_ADDRESS)) bus ();

    memory_loader #(
        .NB_DATA(NB_DATA),
        .NB_ADDRESS(NB_ADDRESS),
        .N_ADDRESS(N_ADDRESS)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Record every memory write, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.o_w_en === 1'b1) begin
            capAddr.push_back(bus.o_w_addr);
            capData.push_back(bus.o_w_data);
        end
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #600000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one byte starting at a falling edge; return at the falling edge after it is taken
    task automatic applyStimulus(input logic [7:0] b);
        int waited;
        waited = 0;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        #1;
        while (bus.o_rx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (bus.o_rx_ready !== 1'b1) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            bus.i_rx_valid = 1'b0;
            @(negedge clk);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idleCycles(input int n);
        bus.i_rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseStart();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic sendFrame(input int gapMax);
        int g;
        foreach (frameBytes[i]) begin
            applyStimulus(frameBytes[i]);
            if (gapMax > 0) begin
                g = $urandom_range(gapMax, 0);
                if (g > 0) idleCycles(g);
            end
        end
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic waitFinished(input string tag);
        int n;
        n = 0;
        while (!(bus.o_done === 1'b1 || bus.o_err === 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("%s_finish", tag), 64'((bus.o_done === 1'b1) || (bus.o_err === 1'b1)), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Frame-level reference: outcome and write list follow from L and the payload bytes
    task automatic checkAgainstModel(input string tag);
        int L;
        int nWrites;
        logic [NB_DATA-1:0] expWord;
        L       = int'(frameBytes[0]);
        nWrites = (L <= N_ADDRESS) ? L : 0;
        checkOutput($sformatf("%s_wr_count", tag), 64'(capAddr.size()), 64'(nWrites));
        for (int i = 0; i < nWrites && i < capAddr.size(); i++) begin
            expWord = '0;
            for (int j = 0; j < NB_BYTES; j++)
                expWord = expWord | (NB_DATA'(frameBytes[1 + NB_BYTES*i + j]) << (8*j));
            checkOutput($sformatf("%s_addr%0d", tag, i), 64'(capAddr[i]), 64'(i));
            checkOutput($sformatf("%s_data%0d", tag, i), 64'(capData[i]), 64'(expWord));
        end
        checkOutput($sformatf("%s_done", tag), 64'(bus.o_done), 64'(L <= N_ADDRESS));
        checkOutput($sformatf("%s_err", tag),  64'(bus.o_err),  64'(L > N_ADDRESS));
        checkOutput($sformatf("%s_busy", tag), 64'(bus.o_busy), 64'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput($sformatf("%s_w_data", tag),   64'(bus.o_w_data),   64'd0);
        checkOutput($sformatf("%s_w_addr", tag),   64'(bus.o_w_addr),   64'd0);
        checkOutput($sformatf("%s_w_en", tag),     64'(bus.o_w_en),     64'd0);
        checkOutput($sformatf("%s_rx_ready", tag), 64'(bus.o_rx_ready), 64'd0);
        checkOutput($sformatf("%s_busy", tag),     64'(bus.o_busy),     64'd0);
        checkOutput($sformatf("%s_done", tag),     64'(bus.o_done),     64'd0);
        checkOutput($sformatf("%s_err", tag),      64'(bus.o_err),      64'd0);
    endtask

    function automatic void clearCapture();
        capAddr.delete();
        capData.delete();
    endfunction

    initial begin
        bus.i_start    = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;

        // Reset state
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of the second word: one write already done, then async clear
        frameBytes = '{8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
        clearCapture();
        pulseStart();
        sendFrame(0);
        checkOutput("mid_busy", 64'(bus.o_busy), 64'd1);
        checkOutput("mid_wr_count", 64'(capAddr.size()), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fully valid two-word frame; the byte held across WRITE must not be lost
        frameBytes = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        clearCapture();
        pulseStart();
        sendFrame(0);
        waitFinished("t2");
        checkAgainstModel("t2");
        if (capData.size() >= 2) begin
            checkOutput("t2_word0_const", 64'(capData[0]), 64'h44332211);
            checkOutput("t2_word1_const", 64'(capData[1]), 64'h88776655);
        end
        checkOutput("t2_hold_addr", 64'(bus.o_w_addr), 64'd1);
        checkOutput("t2_hold_data", 64'(bus.o_w_data), 64'h88776655);

        // Oversized length: error, no writes; next start clears the error
        frameBytes = '{8'h21};
        clearCapture();
        pulseStart();
        sendFrame(0);
        waitFinished("t3");
        checkAgainstModel("t3");
        pulseStart();
        #1;
        checkOutput("t3_err_cleared", 64'(bus.o_err), 64'd0);
        checkOutput("t3_busy_again", 64'(bus.o_busy), 64'd1);
        frameBytes = '{8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        clearCapture();
        @(negedge clk);
        sendFrame(2);
        waitFinished("t3b");
        checkAgainstModel("t3b");

        // Maximum length with random payload and random valid gaps
        frameBytes = '{8'h20};
        for (int i = 0; i < N_ADDRESS * NB_BYTES; i++) frameBytes.push_back(8'($urandom));
        clearCapture();
        pulseStart();
        sendFrame(3);
        waitFinished("t4");
        checkAgainstModel("t4");

        // Start pulse during DATA is ignored; bytes offered in DONE are dropped
        frameBytes = '{8'h02, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        clearCapture();
        pulseStart();
        for (int i = 0; i < 3; i++) applyStimulus(frameBytes[i]);
        bus.i_rx_valid = 1'b0;
        pulseStart();
        checkOutput("t5_busy_after_start", 64'(bus.o_busy), 64'd1);
        for (int i = 3; i < frameBytes.size(); i++) applyStimulus(frameBytes[i]);
        bus.i_rx_valid = 1'b0;
        waitFinished("t5");
        checkAgainstModel("t5");
        bus.i_rx_data  = 8'h5A;
        bus.i_rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("t5_done_ready%0d", i), 64'(bus.o_rx_ready), 64'd0);
            @(negedge clk);
        end
        idleCycles(2);
        checkOutput("t5_no_extra_write", 64'(capAddr.size()), 64'd2);
        checkOutput("t5_still_done", 64'(bus.o_done), 64'd1);

        // Zero length: done right after the accept, no writes, address back at 0
        frameBytes = '{8'h00};
        clearCapture();
        pulseStart();
        applyStimulus(8'h00);
        bus.i_rx_valid = 1'b0;
        checkOutput("t6_done_next_cycle", 64'(bus.o_done), 64'd1);
        checkOutput("t6_addr_zero", 64'(bus.o_w_addr), 64'd0);
        waitFinished("t6");
        checkAgainstModel("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
